serial_sub: RTL and testbench

- Bit-serial WIDTH-bit subtractor that computes diff = a - b - borrow_in, one bit per clock.
- Operands are loaded into shift registers and presented LSB-first to a 1-bit full-subtractor cell; the borrow is registered between bits.
- Consumes results bit by bit and assembles the WIDTH-bit difference and final borrow. It is the sequential driver that sits around the 1-bit full-subtractor stage.
- Area-cheap alternative to a ripple subtractor, for datapaths in the same lab designs.

---
 rtl/sub_pkg.sv | 13 +
 rtl/fsub_cell.sv | 16 +
 rtl/serial_sub.sv | 100 ++++++++++
 tb/tb_serial_sub.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding
// and the default operand width.
package sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fsub_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bin, bout set when the
// column has to borrow from the next bit.
module fsub_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - borrow_in, LSB first,
// one bit per clock through a single fsub_cell with a registered borrow.
module serial_sub
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             cell_d;
    logic             cell_bout;
    logic             last_bit;

    fsub_cell u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (brw),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        last_bit = (state == S_RUN) && (cnt == LAST);
        res_next = {cell_d, res_sr[WIDTH-1:1]};
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last_bit) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // busy/done are decoded from the next state so they leave a flop directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != S_IDLE);
            done  <= (state_next == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        brw  <= borrow_in;
                        cnt  <= '0;
                    end
                end
                S_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    brw    <= cell_bout;
                    res_sr <= res_next;
                    cnt    <= last_bit ? '0 : cnt + CW'(1);
                    if (last_bit) begin
                        diff       <= res_next;
                        borrow_out <= cell_bout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Directed and randomized checks of serial_sub against plain-arithmetic
// expectations, for WIDTH=8 and WIDTH=16 instances sharing one clock.
module tb_serial_sub;

    logic        clk;
    logic        rst_n;

    logic        start8, bin8, busy8, done8, bo8;
    logic [7:0]  a8, b8, diff8;
    logic        start16, bin16, busy16, done16, bo16;
    logic [15:0] a16, b16, diff16;

    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned fails  = 0;

    serial_sub #(.WIDTH(8)) u8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .borrow_in  (bin8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (bo8)
    );

    serial_sub #(.WIDTH(16)) u16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start16),
        .a          (a16),
        .b          (b16),
        .borrow_in  (bin16),
        .busy       (busy16),
        .done       (done16),
        .diff       (diff16),
        .borrow_out (bo16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {borrow, diff} from unsigned arithmetic, one bit wider than the operands.
    function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} - {1'b0, y} - {8'd0, c};
    endfunction

    function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic c);
        return {1'b0, x} - {1'b0, y} - {16'd0, c};
    endfunction

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c, output int lat);
        a8 = x; b8 = y; bin8 = c; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        lat = 0;
        while (!done8 && lat < 40) begin
            tick;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int ndone;
        int last_t;
        logic [8:0]  cap8;
        logic [16:0] cap16;
        logic [8:0]  e8;
        logic [16:0] e16;
        bit g8, g16;

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
        repeat (2) tick;
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        check("rst_diff", diff8, 8'h00);
        check("rst_borrow", bo8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        // Basic operation with latency and busy visibility.
        a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        check("t1_busy", busy8, 1'b1);
        check("t1_done_early", done8, 1'b0);
        lat = 0;
        while (!done8 && lat < 40) begin
            tick;
            lat++;
        end
        check("t1_latency", lat, 8);
        check("t1_diff", diff8, 8'h1E);
        check("t1_borrow", bo8, 1'b0);
        check("t1_busy_done", busy8, 1'b1);
        tick;
        check("t1_done_pulse", done8, 1'b0);
        check("t1_idle", busy8, 1'b0);
        check("t1_hold", diff8, 8'h1E);

        op8(8'h00, 8'h01, 1'b0, lat);
        check("t2a_latency", lat, 8);
        check("t2a", {bo8, diff8}, 9'h1FF);
        tick;
        op8(8'h10, 8'h0F, 1'b1, lat);
        check("t2b", {bo8, diff8}, 9'h000);
        tick;
        op8(8'h77, 8'h77, 1'b0, lat);
        check("eq_b0", {bo8, diff8}, 9'h000);
        tick;
        op8(8'h77, 8'h77, 1'b1, lat);
        check("eq_b1", {bo8, diff8}, 9'h1FF);
        tick;

        // A start pulse during RUN must be ignored.
        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        repeat (3) tick;
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        ndone = 0;
        cap8 = '0;
        for (int t = 5; t <= 18; t++) begin
            tick;
            if (done8) begin
                ndone++;
                cap8 = {bo8, diff8};
            end
        end
        check("t3_ndone", ndone, 1);
        check("t3_result", cap8, 9'h07F);
        check("t3_idle", busy8, 1'b0);

        // Asynchronous reset in the middle of RUN.
        a8 = 8'hAA; b8 = 8'h11; bin8 = 1'b1; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        repeat (4) tick;
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_busy", busy8, 1'b0);
        check("t4_done", done8, 1'b0);
        check("t4_diff", diff8, 8'h00);
        check("t4_borrow", bo8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        op8(8'h03, 8'h05, 1'b0, lat);
        check("t4_latency", lat, 8);
        check("t4_after", {bo8, diff8}, 9'h1FE);
        tick;

        // start held high: one op every WIDTH+2 cycles, result held between.
        a8 = 8'h20; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        ndone = 0;
        last_t = 0;
        for (int t = 1; t <= 32; t++) begin
            tick;
            if (done8) begin
                ndone++;
                if (last_t == 0) check("t5_first", t, 9);
                else check("t5_interval", t - last_t, 10);
                check("t5_diff", {bo8, diff8}, 9'h01F);
                last_t = t;
            end else if (last_t != 0) begin
                check("t5_hold", {bo8, diff8}, 9'h01F);
            end
        end
        check("t5_ndone", ndone, 3);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 40) begin
            tick;
            lat++;
        end
        check("t5_drain", {bo8, diff8}, 9'h01F);
        tick;

        // Random sweep on both widths in lockstep.
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
            if (i % 10 == 0) begin
                a8 = 8'($urandom);
                b8 = a8;
                a16 = 16'($urandom);
                b16 = a16;
            end
            e8 = ref8(a8, b8, bin8);
            e16 = ref16(a16, b16, bin16);
            start8 = 1'b1; start16 = 1'b1;
            tick;
            start8 = 1'b0; start16 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
            g8 = 1'b0; g16 = 1'b0;
            cap8 = '0; cap16 = '0;
            for (int k = 0; k < 40 && !(g8 && g16); k++) begin
                tick;
                if (done8 && !g8) begin
                    g8 = 1'b1;
                    cap8 = {bo8, diff8};
                end
                if (done16 && !g16) begin
                    g16 = 1'b1;
                    cap16 = {bo16, diff16};
                end
            end
            check("rnd8_done", g8, 1'b1);
            check("rnd16_done", g16, 1'b1);
            check("rnd8", cap8, e8);
            check("rnd16", cap16, e16);
            tick;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
